// File: rtl/rd_empty_ctrl.sv
// Read-side control of an asynchronous FIFO: synchronises the Gray write
// pointer, advances the read pointer and derives empty, level and error flags.
module rd_empty_ctrl #(
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_inc,
  input  logic [ADDR_SIZE:0]   wr_ptr,
  input  logic [ADDR_SIZE:0]   ae_thresh,
  input  logic                 clr_err,
  output logic [ADDR_SIZE:0]   rd_ptr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 rd_empty,
  output logic                 rd_almost_empty,
  output logic [ADDR_SIZE:0]   rd_level,
  output logic                 rd_underflow
);

  typedef logic [ADDR_SIZE:0] ptr_t;

  ptr_t sync_q [SYNC_STAGES];
  ptr_t wr_q_ptr;
  ptr_t wr_bin;

  ptr_t rd_bin_q,  rd_bin_d;
  ptr_t rd_ptr_q,  rd_gray_d;
  ptr_t level_q,   level_d;
  logic empty_q,   empty_d;
  logic aempty_q,  aempty_d;
  logic uflow_q,   uflow_d;
  logic rd_fire;

  // Raw wr_ptr goes straight into the first flop; nothing may sit in front of it.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wr_ptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_q_ptr = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    wr_bin = '0;
    for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
      wr_bin[i] = ^(wr_q_ptr >> i);
    end
  end

  always_comb begin
    rd_fire   = rd_inc & ~empty_q;
    rd_bin_d  = rd_bin_q + ptr_t'(rd_fire);
    rd_gray_d = (rd_bin_d >> 1) ^ rd_bin_d;
    empty_d   = (rd_gray_d == wr_q_ptr);
    level_d   = wr_bin - rd_bin_d;
    aempty_d  = (level_d <= ae_thresh);
    // A fresh underflow wins over a same-edge clear.
    uflow_d   = (rd_inc & empty_q) | (uflow_q & ~clr_err);
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      rd_bin_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      level_q  <= '0;
      uflow_q  <= 1'b0;
    end else begin
      rd_bin_q <= rd_bin_d;
      rd_ptr_q <= rd_gray_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      level_q  <= level_d;
      uflow_q  <= uflow_d;
    end
  end

  assign rd_ptr          = rd_ptr_q;
  assign rd_addr         = rd_bin_q[ADDR_SIZE-1:0];
  assign rd_empty        = empty_q;
  assign rd_almost_empty = aempty_q;
  assign rd_level        = level_q;
  assign rd_underflow    = uflow_q;

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Bench for rd_empty_ctrl: fixed vector table, hand sequences for reset,
// wrap and full level, and random traffic against a counter-based model.
module tb_rd_empty_ctrl;

  localparam int AW    = 4;
  localparam int SYNC  = 2;
  localparam int MOD   = 32;
  localparam int DEPTH = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b0;
  logic          rd_inc = 1'b0;
  logic          clr_err = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   ae_thresh = '0;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_addr;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [AW:0]   rd_level;
  logic          rd_underflow;

  rd_empty_ctrl #(.ADDR_SIZE(AW), .SYNC_STAGES(SYNC)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_inc(rd_inc), .wr_ptr(wr_ptr),
    .ae_thresh(ae_thresh), .clr_err(clr_err), .rd_ptr(rd_ptr),
    .rd_addr(rd_addr), .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty),
    .rd_level(rd_level), .rd_underflow(rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int thr    = 2;

  // Model: read count, delay line of visible write counts, flag state.
  int m_rd = 0;
  int m_q[$];
  bit m_empty = 1'b1;
  bit m_ae = 1'b1;
  bit m_uf = 1'b0;
  int m_level = 0;

  typedef struct {
    bit rst; bit inc; bit clr; int wcnt;
    bit e_empty; int e_level; bit e_ae; bit e_uf; int e_ptr; int e_addr;
  } vec_t;
  vec_t tbl[13];

  function automatic int gray(int b);
    int v;
    v = b % MOD;
    return v ^ (v >> 1);
  endfunction

  function automatic int room();
    return ((wr_cnt - m_rd) % MOD + MOD) % MOD;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    int vis;
    bit rd;
    bit uf;
    if (!rd_rst) begin
      m_rd = 0;
      m_q.delete();
      for (int i = 0; i < SYNC; i++) m_q.push_back(0);
      m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0; m_level = 0;
    end else begin
      vis = m_q.pop_front();
      m_q.push_back(wr_cnt % MOD);
      rd = rd_inc && !m_empty;
      uf = rd_inc && m_empty;
      m_rd = (m_rd + (rd ? 1 : 0)) % MOD;
      m_level = ((vis - m_rd) % MOD + MOD) % MOD;
      m_empty = (m_level == 0);
      m_ae = (m_level <= thr);
      m_uf = uf || (m_uf && !clr_err);
    end
  endfunction

  task automatic cyc(input bit rst, input bit inc, input bit clr);
    rd_rst = rst; rd_inc = inc; clr_err = clr;
    wr_ptr = 5'(gray(wr_cnt));
    ae_thresh = 5'(thr);
    @(posedge rd_clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, "_empty"}, int'(rd_empty), int'(m_empty));
    chk({tag, "_level"}, int'(rd_level), m_level);
    chk({tag, "_ae"},    int'(rd_almost_empty), int'(m_ae));
    chk({tag, "_uf"},    int'(rd_underflow), int'(m_uf));
    chk({tag, "_ptr"},   int'(rd_ptr), gray(m_rd));
    chk({tag, "_addr"},  int'(rd_addr), m_rd % DEPTH);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit rst, inc, clr;

    for (int i = 0; i < SYNC; i++) m_q.push_back(0);

    // rst inc clr wcnt | empty level ae uf ptr addr   (ae_thresh = 2)
    tbl = '{
      '{1'b0, 1'b1, 1'b0, 3, 1'b1, 0, 1'b1, 1'b0, 0, 0},
      '{1'b0, 1'b1, 1'b0, 3, 1'b1, 0, 1'b1, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 3, 1'b1, 0, 1'b1, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 3, 1'b1, 0, 1'b1, 1'b0, 0, 0},
      '{1'b1, 1'b0, 1'b0, 3, 1'b0, 3, 1'b0, 1'b0, 0, 0},
      '{1'b1, 1'b1, 1'b0, 3, 1'b0, 2, 1'b1, 1'b0, 1, 1},
      '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1, 1'b1, 1'b0, 3, 2},
      '{1'b1, 1'b1, 1'b0, 3, 1'b1, 0, 1'b1, 1'b0, 2, 3},
      '{1'b1, 1'b1, 1'b0, 3, 1'b1, 0, 1'b1, 1'b1, 2, 3},
      '{1'b1, 1'b0, 1'b0, 3, 1'b1, 0, 1'b1, 1'b1, 2, 3},
      '{1'b1, 1'b1, 1'b1, 3, 1'b1, 0, 1'b1, 1'b1, 2, 3},
      '{1'b1, 1'b0, 1'b1, 3, 1'b1, 0, 1'b1, 1'b0, 2, 3},
      '{1'b1, 1'b0, 1'b0, 3, 1'b1, 0, 1'b1, 1'b0, 2, 3}
    };

    thr = 2;
    foreach (tbl[i]) begin
      wr_cnt = tbl[i].wcnt;
      cyc(tbl[i].rst, tbl[i].inc, tbl[i].clr);
      chk($sformatf("v%0d_empty", i), int'(rd_empty), int'(tbl[i].e_empty));
      chk($sformatf("v%0d_level", i), int'(rd_level), tbl[i].e_level);
      chk($sformatf("v%0d_ae", i),    int'(rd_almost_empty), int'(tbl[i].e_ae));
      chk($sformatf("v%0d_uf", i),    int'(rd_underflow), int'(tbl[i].e_uf));
      chk($sformatf("v%0d_ptr", i),   int'(rd_ptr), tbl[i].e_ptr);
      chk($sformatf("v%0d_addr", i),  int'(rd_addr), tbl[i].e_addr);
    end

    // Level 5, then a one-edge reset pulse and recovery from wr_ptr.
    wr_cnt = 8;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("lvl5_level", int'(rd_level), 5);
    check_model("lvl5");
    rd_rst = 1'b0;
    #1;
    chk("rst_hold_level", int'(rd_level), 5);
    chk("rst_hold_ptr", int'(rd_ptr), 2);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_empty", int'(rd_empty), 1);
    chk("rst_level", int'(rd_level), 0);
    chk("rst_ae", int'(rd_almost_empty), 1);
    chk("rst_uf", int'(rd_underflow), 0);
    chk("rst_ptr", int'(rd_ptr), 0);
    chk("rst_addr", int'(rd_addr), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check_model($sformatf("rec%0d", i));
    end
    chk("rec_level", int'(rd_level), 8);

    // Random traffic; writer never overfills relative to consumed reads.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) thr = $urandom_range(0, DEPTH);
      rst = ($urandom_range(0, 99) != 0);
      if (!rst) wr_cnt = 0;
      else if (room() < DEPTH && $urandom_range(0, 2) != 0) wr_cnt++;
      inc = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      cyc(rst, inc, clr);
      check_model("rnd");
      chk("rnd_level_bound", int'(rd_level <= 5'(DEPTH)), 1);
    end

    // Read up to binary pointer 31, then one more read wraps to 0.
    thr = 2;
    n = 0;
    while (m_rd != MOD - 1 && n < 400) begin
      if (room() < DEPTH) wr_cnt++;
      cyc(1'b1, 1'b1, 1'b0);
      check_model("wrap");
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wrap_reach: got read count %0d expected 31 within 400 cycles", m_rd);
    end
    chk("wrap_ptr31", int'(rd_ptr), 16);
    n = 0;
    while (m_empty && n < 50) begin
      if (room() < DEPTH) wr_cnt++;
      cyc(1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("wrap_nonempty", int'(rd_empty), 0);
    cyc(1'b1, 1'b1, 1'b0);
    check_model("wrap0");
    chk("wrap_ptr0", int'(rd_ptr), 0);
    chk("wrap_addr0", int'(rd_addr), 0);

    // Full level: read pointer at 0, write pointer binary 16.
    wr_cnt = 16;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check_model($sformatf("full%0d", i));
    end
    chk("full_level", int'(rd_level), 16);
    chk("full_ae", int'(rd_almost_empty), 0);
    chk("full_empty", int'(rd_empty), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rd_empty_ctrl.md
RD_EMPTY_CTRL -- requirements
Module: rd_empty_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 4: memory address width; FIFO depth = 2^ADDR_SIZE; legal range 2..12.
REQ-002 Parameter SYNC_STAGES, default 2: flop count in the write-pointer synchroniser; legal range 2..4.
REQ-003 rd_clk  in  1  read-domain clock; the only clock; all flops update on its rising edge.
REQ-004 rd_rst  in  1  reset; synchronous and active-low, sampled on rising rd_clk.
REQ-005 rd_inc  in  1  read request; honoured only when rd_empty=0.
REQ-006 wr_ptr  in  ADDR_SIZE+1  Gray-coded write pointer, asynchronous to rd_clk (raw from write domain).
REQ-007 ae_thresh  in  ADDR_SIZE+1  almost-empty threshold, quasi-static.
REQ-008 clr_err  in  1  clears rd_underflow.
REQ-009 rd_ptr  out  ADDR_SIZE+1  registered Gray read pointer, sent to the write domain.
REQ-010 rd_addr  out  ADDR_SIZE  memory read address.
REQ-011 rd_empty  out  1  registered empty flag.
REQ-012 rd_almost_empty  out  1  registered; 1 when level <= ae_thresh.
REQ-013 rd_level  out  ADDR_SIZE+1  registered fill level as seen by the read domain, 0..2^ADDR_SIZE.
REQ-014 rd_underflow  out  1  sticky read-while-empty error.

Function
REQ-015 wr_ptr SHALL pass through SYNC_STAGES cascaded flops; wr_q_ptr = last stage; no other logic touches wr_ptr before the first stage.
REQ-016 rd_bin (ADDR_SIZE+1 bits) SHALL hold the binary read pointer; rd_bin_next = rd_bin + (rd_inc & ~rd_empty), modulo 2^(ADDR_SIZE+1).
REQ-017 rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next; rd_ptr <= rd_gray_next each cycle.
REQ-018 rd_addr SHALL equal rd_bin[ADDR_SIZE-1:0], the full low field, driven combinationally from the register.
REQ-019 rd_empty <= (rd_gray_next == wr_q_ptr).
REQ-020 wr_bin = Gray-to-binary of wr_q_ptr (XOR prefix from the MSB); level_next = (wr_bin - rd_bin_next) mod 2^(ADDR_SIZE+1); rd_level <= level_next.
REQ-021 rd_almost_empty <= (level_next <= ae_thresh), unsigned compare.
REQ-022 rd_inc=1 with rd_empty=1 SHALL leave rd_bin, rd_ptr and rd_addr unchanged and set rd_underflow on that edge.
REQ-023 rd_underflow SHALL stay set until an edge with clr_err=1 and no new underflow; a simultaneous underflow and clr_err leaves it at 1.
REQ-024 Wrap: rd_bin SHALL go from 2^(ADDR_SIZE+1)-1 to 0 with no stall; rd_addr wraps every 2^ADDR_SIZE reads.
REQ-025 Latency: a wr_ptr change SHALL reach rd_empty, rd_level and rd_almost_empty on rd_clk edge SYNC_STAGES+1 after the change is sampled.
REQ-026 A read on the edge where the last word is consumed SHALL assert rd_empty on that same edge (flag computed from rd_gray_next).
REQ-027 rd_level SHALL never exceed 2^ADDR_SIZE when the write side obeys its full flag.

Reset
REQ-028 While rd_rst=0 at a rising edge, the following SHALL load on that edge: synchroniser flops 0, rd_bin 0, rd_ptr 0, rd_empty 1, rd_almost_empty 1, rd_level 0, rd_underflow 0. rd_addr follows as 0.
REQ-029 Reset SHALL override rd_inc and clr_err; reset mid-operation discards the pointer state with no partial update.
REQ-030 Between assertion and the next rising edge, outputs SHALL keep their prior values (synchronous reset).

Verification (ADDR_SIZE=4, SYNC_STAGES=2)
REQ-031 Hold rd_rst=0 for 2 edges with rd_inc=1 and wr_ptr=5'b00010 -> rd_empty=1, rd_level=0, rd_ptr=0, rd_underflow=0.
REQ-032 After reset, set wr_ptr=5'b00010 (binary 3) and ae_thresh=2 -> on the 3rd edge rd_empty=0, rd_level=3, rd_almost_empty=0. Then do 3 reads -> rd_addr 0,1,2; rd_empty=1 and rd_ptr=5'b00010 on the 3rd read edge.
REQ-033 Set rd_inc=1 while empty -> rd_bin holds and rd_underflow=1 on the next edge. rd_underflow stays 1 until clr_err=1 clears it. With clr_err and an underflow on the same edge -> rd_underflow remains 1.
REQ-034 Wrap: drive reads and writes until rd_bin=31 (rd_ptr=5'b10000), then do one read -> rd_bin=0, rd_ptr=0, rd_addr=0.
REQ-035 Full level: with rd_bin=0, set wr_ptr=5'b11000 (binary 16) -> rd_level=16 and rd_almost_empty=0 after 3 edges.
REQ-036 With rd_level=5, pulse rd_rst=0 for 1 edge -> all reset values on that edge. After release and 3 edges, rd_level is recomputed from wr_ptr.
